// File: rtl/dct_mac_sequencer_if.sv
// -----------------------------------------------------------------------------
// dct_mac_sequencer_if
// Bundles every non-clock/reset signal of the DCT MAC sequencer.
//   clr               flush of the current pass (environment -> sequencer)
//   inValid/inReady   operand-pair stream; inA = sample, inB = coefficient,
//   inA/inB           both 11-bit sign-magnitude (bit 10 = sign)
//   mulA/mulB         registered operands to the shared multiplier
//   mulR/mulSign      multiplier magnitude (20 bit) and sign, combinational
//   outValid/outReady result stream; outData is the two's-complement dot product
//   busy              a pass is in flight (first accept .. result handshake)
// Modport slave is the sequencer's view, master is the surrounding datapath.
// -----------------------------------------------------------------------------
interface dct_mac_sequencer_if #(
  parameter int ACC_W = 24
);
  logic             clr;
  logic             inValid;
  logic             inReady;
  logic [10:0]      inA;
  logic [10:0]      inB;
  logic [10:0]      mulA;
  logic [10:0]      mulB;
  logic [19:0]      mulR;
  logic             mulSign;
  logic             outValid;
  logic             outReady;
  logic [ACC_W-1:0] outData;
  logic             busy;

  modport slave (
    input  clr, inValid, inA, inB, mulR, mulSign, outReady,
    output inReady, mulA, mulB, outValid, outData, busy
  );

  modport master (
    output clr, inValid, inA, inB, mulR, mulSign, outReady,
    input  inReady, mulA, mulB, outValid, outData, busy
  );
endinterface

// File: rtl/dct_mac_sequencer.sv
// -----------------------------------------------------------------------------
// dct_mac_sequencer
// Drives a shared 11-bit sign-magnitude multiplier through an N_TERMS-long dot
// product (one DCT coefficient per pass) and accumulates the signed products in
// two's complement.
// Ports:
//   clk   system clock, all state on the rising edge
//   rst   synchronous active-high reset (wins over bus.clr)
//   bus   dct_mac_sequencer_if.slave: operand stream in, multiplier operand/
//         result port, result stream out, busy flag, clr flush
// Pipeline: a pair accepted at edge t sits in mulA/mulB during the next cycle,
// and its product is added to the accumulator at edge t+1.
// -----------------------------------------------------------------------------
module dct_mac_sequencer #(
  parameter int N_TERMS = 8,
  parameter int ACC_W   = 24
) (
  input logic                  clk,
  input logic                  rst,
  dct_mac_sequencer_if.slave   bus
);

  localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] OUT   = 2'd2;

  logic [1:0]              stateReg;
  logic [CNT_W-1:0]        cntReg;
  logic signed [ACC_W-1:0] accReg;
  logic signed [ACC_W-1:0] accNext;
  logic signed [ACC_W-1:0] magExt;
  logic signed [ACC_W-1:0] prodExt;
  logic                    pValidReg;
  logic [10:0]             mulAReg;
  logic [10:0]             mulBReg;
  logic                    outValidReg;
  logic [ACC_W-1:0]        outDataReg;
  logic                    busyReg;
  logic                    accept;

  assign accept = bus.inValid && (stateReg == RUN);

  // Negating a zero magnitude yields zero, so "negative zero" needs no
  // special case.
  always_comb begin
    magExt  = {{(ACC_W-20){1'b0}}, bus.mulR};
    prodExt = bus.mulSign ? -magExt : magExt;
    accNext = accReg;
    if (pValidReg) begin
      accNext = accReg + prodExt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      stateReg    <= RUN;
      cntReg      <= '0;
      accReg      <= '0;
      pValidReg   <= 1'b0;
      mulAReg     <= '0;
      mulBReg     <= '0;
      outValidReg <= 1'b0;
      outDataReg  <= '0;
      busyReg     <= 1'b0;
    end else begin
      accReg    <= accNext;
      pValidReg <= accept;
      if (accept) begin
        mulAReg <= bus.inA;
        mulBReg <= bus.inB;
        busyReg <= 1'b1;
      end

      case (stateReg)
        RUN: begin
          if (accept) begin
            if (cntReg == LAST_CNT) begin
              cntReg   <= '0;
              stateReg <= DRAIN;
            end else begin
              cntReg <= cntReg + CNT_W'(1);
            end
          end
        end
        DRAIN: begin
          // The last product lands in accNext this edge; publish it directly.
          stateReg    <= OUT;
          outValidReg <= 1'b1;
          outDataReg  <= accNext;
        end
        OUT: begin
          if (bus.outReady) begin
            outValidReg <= 1'b0;
            accReg      <= '0;
            busyReg     <= 1'b0;
            stateReg    <= RUN;
          end
        end
        default: begin
          stateReg <= RUN;
        end
      endcase
    end
  end

  assign bus.inReady  = (stateReg == RUN);
  assign bus.mulA     = mulAReg;
  assign bus.mulB     = mulBReg;
  assign bus.outValid = outValidReg;
  assign bus.outData  = outDataReg;
  assign bus.busy     = busyReg;

endmodule

// File: tb/tb_dct_mac_sequencer.sv
module tb_dct_mac_sequencer;
  localparam int N     = 8;
  localparam int ACC_W = 24;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   readyMode = 0;   // 0: always ready, 1: random, 2: hold low
  int   resultNo = 0;
  logic [ACC_W-1:0] sb[$];
  logic [10:0] pa [N];
  logic [10:0] pb [N];

  dct_mac_sequencer_if #(.ACC_W(ACC_W)) bus ();

  dct_mac_sequencer #(.N_TERMS(N), .ACC_W(ACC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural shared multiplier.
  assign bus.mulR    = 20'(bus.mulA[9:0]) * 20'(bus.mulB[9:0]);
  assign bus.mulSign = bus.mulA[10] ^ bus.mulB[10];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic longint smVal(input logic [10:0] x);
    return x[10] ? -longint'(x[9:0]) : longint'(x[9:0]);
  endfunction

  function automatic logic [ACC_W-1:0] refDot(input logic [10:0] as [N], input logic [10:0] bs [N]);
    longint sum = 0;
    for (int k = 0; k < N; k++) sum += smVal(as[k]) * smVal(bs[k]);
    return ACC_W'(sum);
  endfunction

  always @(posedge clk) begin
    #1;
    case (readyMode)
      0:       bus.outReady = 1'b1;
      1:       bus.outReady = 1'($urandom_range(0, 1));
      default: bus.outReady = 1'b0;
    endcase
  end

  // Monitor / scoreboard
  logic             prevHold = 1'b0;
  logic [ACC_W-1:0] prevData = '0;
  always @(negedge clk) begin
    if (rst || bus.clr) begin
      prevHold = 1'b0;
    end else begin
      if (prevHold) begin
        check("hold_valid", 64'(bus.outValid), 64'd1);
        check("hold_data", 64'(bus.outData), 64'(prevData));
      end
      if (bus.outValid) begin
        check("spurious_out_valid", 64'(sb.size() != 0), 64'd1);
        if (bus.outReady && sb.size() != 0) begin
          logic [ACC_W-1:0] exp;
          exp = sb.pop_front();
          resultNo++;
          $display("result %0d out_data=%06h expected=%06h", resultNo, bus.outData, exp);
          check("result", 64'(bus.outData), 64'(exp));
        end
      end
      prevHold = bus.outValid && !bus.outReady;
      prevData = bus.outData;
    end
  end

  task automatic idle();
    bus.inValid = 1'b0;
    bus.inA = 11'($urandom);
    bus.inB = 11'($urandom);
    @(posedge clk); #1;
  endtask

  task automatic sendPair(input logic [10:0] a, input logic [10:0] b);
    int n = 0;
    bus.inValid = 1'b1;
    bus.inA = a;
    bus.inB = b;
    @(negedge clk);
    while (!bus.inReady && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bus.inReady) check("send_timeout", 64'(bus.inReady), 64'd1);
    @(posedge clk); #1;
    bus.inValid = 1'b0;
  endtask

  // gapMode: 0 back-to-back, 1 gap every other cycle, 2 random gaps
  task automatic runPass(input int gapMode);
    for (int k = 0; k < N; k++) begin
      sendPair(pa[k], pb[k]);
      if (k < N - 1) begin
        if (gapMode == 1 || (gapMode == 2 && $urandom_range(0, 2) == 0)) idle();
      end
    end
    sb.push_back(refDot(pa, pb));
  endtask

  task automatic waitEmpty();
    int n = 0;
    while (sb.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 64'(sb.size() == 0), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic waitOutValid();
    int n = 0;
    @(negedge clk);
    while (!bus.outValid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("out_valid_timeout", 64'(bus.outValid), 64'd1);
  endtask

  task automatic loadMixed();
    pa[0] = 11'h005; pb[0] = 11'h403;
    pa[1] = 11'h407; pb[1] = 11'h402;
    for (int k = 2; k < N; k++) begin
      pa[k] = 11'h000; pb[k] = 11'h401;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.clr = 1'b0;
    bus.inValid = 1'b1;
    bus.inA = 11'h3FF;
    bus.inB = 11'h3FF;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.inValid = 1'b0;
    @(negedge clk);
    check("reset_in_ready", 64'(bus.inReady), 64'd1);
    check("reset_out_valid", 64'(bus.outValid), 64'd0);
    check("reset_mul_a", 64'(bus.mulA), 64'd0);
    check("reset_mul_b", 64'(bus.mulB), 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_out_data", 64'(bus.outData), 64'd0);
    @(posedge clk); #1;

    // Full-scale positive products, back to back, with latency checks.
    for (int k = 0; k < N; k++) begin
      pa[k] = 11'h3FF; pb[k] = 11'h3FF;
    end
    check("model_full_scale", 64'(refDot(pa, pb)), 64'h7FC008);
    runPass(0);
    @(negedge clk);
    check("drain_in_ready", 64'(bus.inReady), 64'd0);
    check("drain_out_valid", 64'(bus.outValid), 64'd0);
    check("drain_busy", 64'(bus.busy), 64'd1);
    @(negedge clk);
    check("out_out_valid", 64'(bus.outValid), 64'd1);
    check("out_in_ready", 64'(bus.inReady), 64'd0);
    waitEmpty();
    @(negedge clk);
    check("idle_busy", 64'(bus.busy), 64'd0);
    check("idle_in_ready", 64'(bus.inReady), 64'd1);
    @(posedge clk); #1;

    // Mixed signs including negative zero.
    loadMixed();
    runPass(0);
    waitEmpty();

    // Gaps plus backpressure, then a clean repeat of the same pass.
    readyMode = 2;
    runPass(1);
    waitOutValid();
    repeat (5) @(negedge clk);
    readyMode = 0;
    waitEmpty();
    runPass(0);
    waitEmpty();

    // clr after four accepted terms.
    for (int k = 0; k < 4; k++) sendPair(11'($urandom), 11'($urandom));
    bus.clr = 1'b1;
    @(posedge clk); #1;
    bus.clr = 1'b0;
    @(negedge clk);
    check("clr_busy", 64'(bus.busy), 64'd0);
    check("clr_in_ready", 64'(bus.inReady), 64'd1);
    @(posedge clk); #1;
    for (int k = 0; k < N; k++) begin
      pa[k] = 11'h002; pb[k] = 11'h003;
    end
    runPass(0);
    waitEmpty();

    // rst while the result is waiting in OUT.
    for (int k = 0; k < N; k++) begin
      pa[k] = 11'($urandom); pb[k] = 11'($urandom);
    end
    readyMode = 2;
    runPass(2);
    waitOutValid();
    @(posedge clk); #1;
    rst = 1'b1;
    void'(sb.pop_front());
    @(posedge clk); #1;
    rst = 1'b0;
    readyMode = 0;
    @(negedge clk);
    check("rst_out_valid", 64'(bus.outValid), 64'd0);
    check("rst_in_ready", 64'(bus.inReady), 64'd1);
    check("rst_busy", 64'(bus.busy), 64'd0);
    @(posedge clk); #1;
    for (int k = 0; k < N; k++) begin
      pa[k] = 11'h001; pb[k] = 11'h001;
    end
    runPass(0);
    waitEmpty();

    // Randomized passes with random gaps and random backpressure.
    readyMode = 1;
    for (int p = 0; p < 20; p++) begin
      for (int k = 0; k < N; k++) begin
        pa[k] = 11'($urandom); pb[k] = 11'($urandom);
      end
      runPass(2);
    end
    readyMode = 0;
    waitEmpty();
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    check("result_count", 64'(resultNo), 64'd26);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
